// File: rtl/adc_multich_access_counter_if.sv
// BRAM port snooped by the multi-channel ADC consumer tracker.
// The PS-side BRAM controller drives it; the tracker only listens.
interface adc_multich_access_counter_if #(
  parameter int BRAM_ADDR_BITS = 32
);
  logic [BRAM_ADDR_BITS-1:0] bram_addr;
  logic                      en;
  logic [3:0]                we;

  modport master (output bram_addr, en, we);
  modport slave  (input  bram_addr, en, we);
endinterface

// File: rtl/adc_multich_access_counter.sv
// Per-channel consumer pointer, fill level, irq and overrun tracker.
// Optional ADC_ACCESS_SEQ_CHECK_EN adds a sticky non-sequential-read flag.
module adc_multich_access_counter #(
  parameter int ADC_BITS       = 10,
  parameter int CH_BITS        = 2,
  parameter int NUM_CH         = 4,
  parameter int BRAM_ADDR_BITS = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_CH*ADC_BITS-1:0] ADC_buffer_prod_in,
  output logic [NUM_CH*ADC_BITS-1:0] ADC_buffer_cons_out,
  output logic [NUM_CH*ADC_BITS-1:0] ADC_level_out,
  input  logic [ADC_BITS-1:0]        threshold_in,
  input  logic [NUM_CH-1:0]          clear_in,
  output logic [NUM_CH-1:0]          irq_out,
  output logic [NUM_CH-1:0]          overrun_out,
  output logic [NUM_CH-1:0]          seq_err_out,
  adc_multich_access_counter_if.slave bram
);

  typedef logic [ADC_BITS-1:0] ptr_t;

  logic               rd;
  ptr_t               idx;
  logic [CH_BITS-1:0] ch;
  logic               unused_addr;

  assign rd  = bram.en && (bram.we == 4'b0000);
  assign idx = bram.bram_addr[ADC_BITS+1:2];
  assign ch  = bram.bram_addr[ADC_BITS+CH_BITS+1:ADC_BITS+2];
  assign unused_addr = ^{
    bram.bram_addr[BRAM_ADDR_BITS-1:ADC_BITS+CH_BITS+2],
    bram.bram_addr[1:0]};

  ptr_t              cons_q  [NUM_CH];
  ptr_t              prod_q  [NUM_CH];
  ptr_t              level_q [NUM_CH];
  ptr_t              prod_a  [NUM_CH];
  ptr_t              diff    [NUM_CH];
  logic [NUM_CH-1:0] hit;
  logic [NUM_CH-1:0] prod_chg_q;
  logic [NUM_CH-1:0] cons_chg_q;
  logic [NUM_CH-1:0] irq_q;
  logic [NUM_CH-1:0] ovr_q;

  // Channel selects beyond NUM_CH never match, so they leave state alone
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      hit[c]    = rd && (ch == CH_BITS'(c));
      prod_a[c] = ADC_buffer_prod_in[c*ADC_BITS +: ADC_BITS];
      diff[c]   = prod_q[c] - cons_q[c];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        cons_q[c]  <= '0;
        prod_q[c]  <= '0;
        level_q[c] <= '0;
      end
      prod_chg_q <= '0;
      cons_chg_q <= '0;
      irq_q      <= '0;
      ovr_q      <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        prod_q[c]     <= prod_a[c];
        prod_chg_q[c] <= prod_a[c] != prod_q[c];
        cons_chg_q[c] <= hit[c];
        if (hit[c]) cons_q[c] <= idx + ptr_t'(1);
        level_q[c] <= diff[c];
        irq_q[c]   <= (threshold_in != '0) &&
                      (diff[c] >= threshold_in);
        // Producer landed on the consumer without a read racing it
        ovr_q[c]   <= (prod_chg_q[c] && !cons_chg_q[c] &&
                       (prod_q[c] == cons_q[c])) ||
                      (ovr_q[c] && !clear_in[c]);
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_out
    assign ADC_buffer_cons_out[g*ADC_BITS +: ADC_BITS] = cons_q[g];
    assign ADC_level_out[g*ADC_BITS +: ADC_BITS]       = level_q[g];
  end

  assign irq_out     = irq_q;
  assign overrun_out = ovr_q;

`ifdef ADC_ACCESS_SEQ_CHECK_EN
  logic [NUM_CH-1:0] seq_hit_q;
  logic [NUM_CH-1:0] seq_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_hit_q <= '0;
      seq_q     <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        seq_hit_q[c] <= hit[c] && (idx != cons_q[c]);
        seq_q[c]     <= seq_hit_q[c] || (seq_q[c] && !clear_in[c]);
      end
    end
  end

  assign seq_err_out = seq_q;
`else
  assign seq_err_out = '0;
`endif

endmodule

// File: tb/tb_adc_multich_access_counter.sv
// Bench for adc_multich_access_counter: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_adc_multich_access_counter;
  localparam int AB  = 10;
  localparam int CB  = 2;
  localparam int NCH = 4;
  localparam int BA  = 32;
`ifdef ADC_ACCESS_SEQ_CHECK_EN
  localparam logic SEQ_EN = 1'b1;
`else
  localparam logic SEQ_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [NCH*AB-1:0] prod_in = '0;
  logic [NCH*AB-1:0] cons_out;
  logic [NCH*AB-1:0] level_out;
  logic [AB-1:0]     thr = '0;
  logic [NCH-1:0]    clr = '0;
  logic [NCH-1:0]    irq;
  logic [NCH-1:0]    ovr;
  logic [NCH-1:0]    seq;

  int n_chk = 0;
  int n_fail = 0;

  logic [AB-1:0]  m_cons  [NCH];
  logic [AB-1:0]  m_prod  [NCH];
  logic [AB-1:0]  e_level [NCH];
  logic [NCH-1:0] e_irq = '0;
  logic [NCH-1:0] e_ovr = '0;
  logic [NCH-1:0] e_seq = '0;
  logic [NCH-1:0] p_ovr = '0;
  logic [NCH-1:0] p_seq = '0;

  adc_multich_access_counter_if #(.BRAM_ADDR_BITS(BA)) bif ();

  adc_multich_access_counter #(
    .ADC_BITS(AB), .CH_BITS(CB), .NUM_CH(NCH), .BRAM_ADDR_BITS(BA)
  ) dut (
    .clk                 (clk),
    .reset               (rst_n),
    .ADC_buffer_prod_in  (prod_in),
    .ADC_buffer_cons_out (cons_out),
    .ADC_level_out       (level_out),
    .threshold_in        (thr),
    .clear_in            (clr),
    .irq_out             (irq),
    .overrun_out         (ovr),
    .seq_err_out         (seq),
    .bram                (bif.slave)
  );

  always #5 clk = ~clk;

  function automatic logic [AB-1:0] cons_of(input int c);
    return cons_out[c*AB +: AB];
  endfunction

  function automatic logic [AB-1:0] lvl_of(input int c);
    return level_out[c*AB +: AB];
  endfunction

  function automatic logic [NCH*AB-1:0] pack(input logic [AB-1:0] a[NCH]);
    logic [NCH*AB-1:0] v;
    for (int c = 0; c < NCH; c++) v[c*AB +: AB] = a[c];
    return v;
  endfunction

  task automatic set_prod(input int c, input int v);
    prod_in[c*AB +: AB] = AB'(v);
  endtask

  task automatic rd(input int c, input int i);
    bif.en = 1'b1;
    bif.we = 4'h0;
    bif.bram_addr = BA'((c << (AB + 2)) | (i << 2));
  endtask

  task automatic idle();
    bif.en = 1'b0;
    bif.we = 4'h0;
  endtask

  // Reference model: advances on every rising edge from the applied inputs
  task automatic tick();
    logic          rdq;
    logic          rdc;
    logic [AB-1:0] idx;
    logic [AB-1:0] np;
    logic [AB-1:0] nc;
    int            ch;
    @(posedge clk);
    rdq = bif.en && (bif.we == 4'h0);
    idx = bif.bram_addr[AB+1:2];
    ch  = int'(bif.bram_addr[AB+CB+1:AB+2]);
    if (!rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        m_cons[c] = '0;
        m_prod[c] = '0;
        e_level[c] = '0;
      end
      e_irq = '0; e_ovr = '0; e_seq = '0;
      p_ovr = '0; p_seq = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        e_level[c] = m_prod[c] - m_cons[c];
        e_irq[c] = (thr != 0) && (e_level[c] >= thr);
        e_ovr[c] = p_ovr[c] | (e_ovr[c] & ~clr[c]);
        if (SEQ_EN) e_seq[c] = p_seq[c] | (e_seq[c] & ~clr[c]);
        rdc = rdq && (ch == c);
        np = prod_in[c*AB +: AB];
        nc = rdc ? idx + 10'd1 : m_cons[c];
        p_ovr[c] = (np != m_prod[c]) && !rdc && (np == nc);
        p_seq[c] = rdc && (idx != m_cons[c]);
        m_prod[c] = np;
        m_cons[c] = nc;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    tick();
    tick();
    n_chk++;
    if ({cons_out, level_out, irq, ovr, seq} !== '0) begin
      n_fail++;
      $display("FAIL reset: got cons=%h lvl=%h irq=%b ovr=%b seq=%b expected all 0",
               cons_out, level_out, irq, ovr, seq);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_seq_reads();
    for (int i = 0; i < 3; i++) begin
      rd(0, i);
      tick();
      n_chk++;
      if (cons_of(0) !== AB'(i + 1)) begin
        n_fail++;
        $display("FAIL seq_read%0d: cons0 got %0d expected %0d",
                 i, cons_of(0), i + 1);
      end
    end
    idle();
    tick();
    tick();
    n_chk++;
    if (seq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_read_err: seq0 got %b expected 0", seq[0]);
    end
  endtask

  task automatic test_level_irq();
    thr = 10'd64;
    set_prod(1, 100);
    tick();
    tick();
    n_chk++;
    if (lvl_of(1) !== 10'd100 || irq[1] !== 1'b1) begin
      n_fail++;
      $display("FAIL level_irq_a: lvl1=%0d irq1=%b expected 100 1",
               lvl_of(1), irq[1]);
    end
    rd(1, 40);
    tick();
    idle();
    n_chk++;
    if (cons_of(1) !== 10'd41) begin
      n_fail++;
      $display("FAIL level_cons1: got %0d expected 41", cons_of(1));
    end
    tick();
    n_chk++;
    if (lvl_of(1) !== 10'd59 || irq[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL level_irq_b: lvl1=%0d irq1=%b expected 59 0",
               lvl_of(1), irq[1]);
    end
  endtask

  task automatic test_wrap();
    rd(2, 1023);
    tick();
    idle();
    n_chk++;
    if (cons_of(2) !== 10'd0) begin
      n_fail++;
      $display("FAIL wrap_cons2: got %0d expected 0", cons_of(2));
    end
    set_prod(2, 5);
    tick();
    tick();
    n_chk++;
    if (lvl_of(2) !== 10'd5) begin
      n_fail++;
      $display("FAIL wrap_level2: got %0d expected 5", lvl_of(2));
    end
  endtask

  task automatic test_overrun();
    rd(3, 9);
    set_prod(3, 9);
    tick();
    idle();
    set_prod(3, 10);
    tick();
    n_chk++;
    if (ovr[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_early: got %b expected 0", ovr[3]);
    end
    tick();
    n_chk++;
    if (ovr[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set: got %b expected 1", ovr[3]);
    end
    rd(3, 10);
    tick();
    rd(3, 11);
    tick();
    idle();
    tick();
    n_chk++;
    if (ovr[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_hold: got %b expected 1", ovr[3]);
    end
    clr[3] = 1'b1;
    tick();
    clr = '0;
    n_chk++;
    if (ovr[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: got %b expected 0", ovr[3]);
    end
    set_prod(3, 12);
    tick();
    clr[3] = 1'b1;
    tick();
    clr = '0;
    n_chk++;
    if (ovr[3] !== 1'b1) begin
      n_fail++;
      $display("FAIL ovr_set_wins: got %b expected 1", ovr[3]);
    end
    clr[3] = 1'b1;
    tick();
    clr = '0;
    rd(3, 12);
    set_prod(3, 13);
    tick();
    idle();
    tick();
    n_chk++;
    if (ovr[3] !== 1'b0 || cons_of(3) !== 10'd13) begin
      n_fail++;
      $display("FAIL ovr_race: ovr3=%b cons3=%0d expected 0 13",
               ovr[3], cons_of(3));
    end
    tick();
    n_chk++;
    if (lvl_of(3) !== 10'd0) begin
      n_fail++;
      $display("FAIL ovr_race_lvl: got %0d expected 0", lvl_of(3));
    end
  endtask

  task automatic test_seq_err();
    rd(0, 7);
    tick();
    idle();
    n_chk++;
    if (cons_of(0) !== 10'd8 || seq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_err_a: cons0=%0d seq0=%b expected 8 0",
               cons_of(0), seq[0]);
    end
    tick();
    n_chk++;
    if (seq[0] !== SEQ_EN) begin
      n_fail++;
      $display("FAIL seq_err_set: got %b expected %b", seq[0], SEQ_EN);
    end
    clr[0] = 1'b1;
    tick();
    clr = '0;
    n_chk++;
    if (seq[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL seq_err_clear: got %b expected 0", seq[0]);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) begin
      rd(1, 100 + i);
      tick();
      n_chk++;
      if (cons_of(1) !== AB'(101 + i)) begin
        n_fail++;
        $display("FAIL b2b%0d: cons1 got %0d expected %0d",
                 i, cons_of(1), 101 + i);
      end
    end
    idle();
    tick();
  endtask

  task automatic test_write_reset();
    bif.en = 1'b1;
    bif.we = 4'hF;
    bif.bram_addr = 32'h0000_0040;
    tick();
    idle();
    n_chk++;
    if (cons_of(0) !== 10'd8) begin
      n_fail++;
      $display("FAIL write_ignored: cons0 got %0d expected 8", cons_of(0));
    end
    rd(0, 8);
    tick();
    rd(0, 9);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    idle();
    n_chk++;
    if ({cons_out, level_out, irq, ovr, seq} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: cons=%h lvl=%h irq=%b ovr=%b seq=%b expected all 0",
               cons_out, level_out, irq, ovr, seq);
    end
  endtask

  task automatic test_random();
    int c;
    int bad;
    bad = 0;
    for (int n = 0; n < 3000; n++) begin
      rst_n = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      if ($urandom_range(0, 15) == 0)
        thr = ($urandom_range(0, 3) == 0) ? '0 : AB'($urandom_range(0, 1023));
      c = $urandom_range(0, NCH - 1);
      if ($urandom_range(0, 3) != 0) begin
        rd(c, ($urandom_range(0, 1) == 0) ? int'(m_cons[c])
                                          : $urandom_range(0, 1023));
        if ($urandom_range(0, 5) == 0) bif.we = 4'($urandom_range(1, 15));
      end else begin
        idle();
      end
      if ($urandom_range(0, 2) == 0) begin
        c = $urandom_range(0, NCH - 1);
        set_prod(c, ($urandom_range(0, 1) == 0) ? int'(m_cons[c])
                                                : $urandom_range(0, 1023));
      end
      clr = ($urandom_range(0, 7) == 0) ? 4'($urandom) : '0;
      tick();
      n_chk++;
      if (cons_out !== pack(m_cons) || level_out !== pack(e_level)) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL rnd_ptr@%0d: cons=%h lvl=%h expected %h %h",
                   n, cons_out, level_out, pack(m_cons), pack(e_level));
      end
      n_chk++;
      if (irq !== e_irq || ovr !== e_ovr || seq !== e_seq) begin
        n_fail++;
        if (bad++ < 10)
          $display("FAIL rnd_flag@%0d: irq=%b ovr=%b seq=%b expected %b %b %b",
                   n, irq, ovr, seq, e_irq, e_ovr, e_seq);
      end
    end
    rst_n = 1'b1;
    clr = '0;
    idle();
  endtask

  initial begin
    bif.bram_addr = '0;
    bif.en = 1'b0;
    bif.we = 4'h0;
    test_reset();
    test_seq_reads();
    test_level_irq();
    test_wrap();
    test_overrun();
    test_seq_err();
    test_back_to_back();
    test_write_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/adc_multich_access_counter.md
# adc_multich_access_counter

Multi-channel successor to the single-channel virtual-ADC consumer tracker. Snoops the processor-side BRAM port of the virtual ADC buffer, which is split into `NUM_CH` equal circular regions. Per channel it:
- tracks the consumer pointer and compares it with the producer pointer from the ADC emulator;
- derives fill level, threshold interrupt and sticky overrun flags.

Sits between the PS-side BRAM controller and the virtual ADC producer logic.

## Interface
Parameters:
- `ADC_BITS`, 10, log2 of words per channel region; width of every pointer/level
- `CH_BITS`, 2, channel-select address bits
- `NUM_CH`, 4, channels implemented (≤ 2^CH_BITS)
- `BRAM_ADDR_BITS`, 32, BRAM byte-address width (≥ ADC_BITS+CH_BITS+2)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-low reset
- `ADC_buffer_prod_in`  in  NUM_CH*ADC_BITS  producer pointers, channel c at [c*ADC_BITS +: ADC_BITS]
- `ADC_buffer_cons_out`  out  NUM_CH*ADC_BITS  consumer pointers (next index to read), same packing
- `ADC_level_out`  out  NUM_CH*ADC_BITS  fill level per channel
- `threshold_in`  in  ADC_BITS  irq threshold, shared by all channels; 0 disables irq
- `clear_in`  in  NUM_CH  one-cycle pulse per channel, clears sticky flags
- `irq_out`  out  NUM_CH  level ≥ threshold
- `overrun_out`  out  NUM_CH  sticky, producer caught consumer
- `seq_err_out`  out  NUM_CH  sticky, non-sequential read (see Configuration)
- `bram_addr`  in  BRAM_ADDR_BITS  BRAM byte address
- `en`  in  1  BRAM enable
- `we`  in  4  BRAM byte write enables

## Operation
- Qualifying read: `en`=1 and `we`=4'b0000. Writes and idle cycles are ignored.
- Decode: index = `bram_addr[ADC_BITS+1:2]`; channel = `bram_addr[ADC_BITS+CH_BITS+1:ADC_BITS+2]`. Channel ≥ NUM_CH: ignored, no state change.
- On a qualifying read of channel c, cons[c] ← index+1 mod 2^ADC_BITS, wrapping 2^ADC_BITS−1 to 0. Other channels are unchanged.
- prod_q[c] registers `ADC_buffer_prod_in` every cycle.
- level[c] = (prod_q[c] − cons[c]) mod 2^ADC_BITS, registered. Empty ⇔ level = 0.
- irq[c] = (threshold_in ≠ 0) and (level[c] ≥ threshold_in), registered, level-sensitive.
- Overrun: set when prod_q[c] changed this cycle, cons[c] did not change this cycle, and the new prod_q[c] equals cons[c]. It stays set until clear_in[c].
- Sticky set and clear_in in the same cycle: set wins.
- Reset (reset=0 at an edge) zeroes cons, prod_q, level, irq, overrun and seq_err. Reset overrides every other event, including mid-burst.

## Timing
- Read at edge t: cons visible after edge t+1.
- level and irq from a read: after edge t+2.
- prod_in change: prod_q after the next edge. level, irq and overrun follow one edge later.
- Back-to-back reads every cycle are supported. Each read updates cons, and the last one wins.
- Read and producer change on the same channel in the same cycle: both take effect. Overrun is not set in that cycle.
- All outputs are 0 in the cycle after reset.

## Configuration
- `ADC_ACCESS_SEQ_CHECK_EN` defined: on a qualifying read, seq_err[c] sets if index ≠ cons[c]. The flag is sticky and cleared by clear_in[c] or reset; latency matches overrun. The cons update happens regardless.
- Not defined: `seq_err_out` is tied to 0 and no checker logic is instantiated.

## Test plan
- Reset, then reads of ch0 at byte addr 0x000, 0x004, 0x008 → cons0 = 1, 2, 3 (1 edge after each read). seq_err0 stays 0.
- prod1 = 100 with cons1 = 0 and threshold 64 → level1 = 100 and irq1 = 1 at edge 2. A read of ch1 index 40 → cons1 = 41, level1 = 59, irq1 = 0.
- Wrap: read ch2 index 1023 (addr 0x2FFC) → cons2 = 0. Then prod2 = 5 → level2 = 5.
- Overrun: cons3 = 10, prod3 stepped 9→10 with no read → overrun3 = 1. It holds through further reads. A clear_in[3] pulse gives 0 next edge. Set and clear in the same cycle → stays 1.
- With the macro defined: read ch0 index 7 while cons0 = 3 → seq_err0 = 1 and cons0 = 8. Without the macro → seq_err0 stays 0.
- A write (we = 4'hF) to ch0, then a mid-stream reset pulse → cons unchanged by the write. All outputs are 0 after the reset edge.
